// File: rtl/dtw_accel_v1_0_m00_axis.sv
// AXI4-Stream master that drains DTW result words from a small FIFO through a
// registered output stage. Optional sticky overflow flag: define DTW_RES_OVF_EN.
module dtw_accel_v1_0_m00_axis #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int C_FIFO_DEPTH         = 16,
  parameter int C_PKT_LEN            = 64
) (
  input  logic                              M_AXIS_ACLK,
  input  logic                              M_AXIS_ARESETN,
  input  logic                              dtw_res_wren,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   dtw_res_din,
  input  logic                              dtw_res_last,
  output logic                              dtw_res_full,
  output logic                              dtw_res_ovf,
  output logic                              M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY
);

  localparam int DW = C_M_AXIS_TDATA_WIDTH;
  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam int CW = $clog2(C_FIFO_DEPTH + 1);
  localparam int PW = (C_PKT_LEN > 1) ? $clog2(C_PKT_LEN) : 1;

  typedef enum logic {OUT_EMPTY, OUT_VALID} out_state_e;

  out_state_e     state_q, state_d;
  logic [DW:0]    mem [C_FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           full_q, full_d;
  logic [DW-1:0]  tdata_q, tdata_d;
  logic           last_q, last_d;
  logic [PW-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic           push, pop, handshake, tvalid, tlast, fifo_nonempty;

  assign fifo_nonempty = (count_q != '0);
  assign push          = dtw_res_wren && !full_q;
  assign tlast         = last_q || (pkt_cnt_q == PW'(C_PKT_LEN - 1));

  // State register.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) state_q <= OUT_EMPTY;
    else                 state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    case (state_q)
      OUT_EMPTY: if (fifo_nonempty)               state_d = OUT_VALID;
      OUT_VALID: if (handshake && !fifo_nonempty) state_d = OUT_EMPTY;
      default:                                    state_d = OUT_EMPTY;
    endcase
  end

  // FSM outputs: the head is popped whenever the output register is free or
  // is being emptied by a handshake this cycle.
  always_comb begin
    tvalid    = (state_q == OUT_VALID);
    handshake = tvalid && M_AXIS_TREADY;
    pop       = fifo_nonempty && ((state_q == OUT_EMPTY) || handshake);
  end

  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d    = (count_d == CW'(C_FIFO_DEPTH));
    tdata_d   = tdata_q;
    last_d    = last_q;
    if (pop) {last_d, tdata_d} = mem[rd_ptr_q];
    pkt_cnt_d = pkt_cnt_q;
    if (handshake) pkt_cnt_d = tlast ? '0 : pkt_cnt_q + PW'(1);
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!M_AXIS_ARESETN) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      tdata_q   <= '0;
      last_q    <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      tdata_q   <= tdata_d;
      last_q    <= last_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  // NOTE: the storage array has no reset; pointers and count define which entries are live.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (push) mem[wr_ptr_q] <= {dtw_res_last, dtw_res_din};
  end

`ifdef DTW_RES_OVF_EN
  logic ovf_q, ovf_d;

  assign ovf_d = ovf_q || (dtw_res_wren && full_q);

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) ovf_q <= 1'b0;
    else                 ovf_q <= ovf_d;
  end

  assign dtw_res_ovf = ovf_q;
`else
  assign dtw_res_ovf = 1'b0;
`endif

  assign dtw_res_full  = full_q;
  assign M_AXIS_TVALID = tvalid;
  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TLAST  = tvalid && tlast;
  assign M_AXIS_TSTRB  = '1;

endmodule

// File: tb/tb_dtw_accel_v1_0_m00_axis.sv
// Directed bench for dtw_accel_v1_0_m00_axis: latency, full/drop, packet TLAST,
// random back-pressure, mid-packet reset and the overflow flag.
module tb_dtw_accel_v1_0_m00_axis;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int PKT   = 4;
`ifdef DTW_RES_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wren = 1'b0;
  logic [DW-1:0] din = '0;
  logic          last = 1'b0;
  logic          full, ovf, tvalid, tlast;
  logic [DW-1:0] tdata;
  logic [DW/8-1:0] tstrb;
  logic          tready = 1'b0;

  always #5 clk = ~clk;

  dtw_accel_v1_0_m00_axis #(
    .C_M_AXIS_TDATA_WIDTH(DW),
    .C_FIFO_DEPTH(DEPTH),
    .C_PKT_LEN(PKT)
  ) dut (
    .M_AXIS_ACLK(clk),
    .M_AXIS_ARESETN(rst_n),
    .dtw_res_wren(wren),
    .dtw_res_din(din),
    .dtw_res_last(last),
    .dtw_res_full(full),
    .dtw_res_ovf(ovf),
    .M_AXIS_TVALID(tvalid),
    .M_AXIS_TDATA(tdata),
    .M_AXIS_TSTRB(tstrb),
    .M_AXIS_TLAST(tlast),
    .M_AXIS_TREADY(tready)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  logic [DW:0] wr_q[$];
  logic [DW:0] rx_q[$];
  logic        prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic        prev_last;

  // Beat collector and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_tvalid", tvalid, 1);
        check("stall_tdata", tdata, prev_data);
        check("stall_tlast", tlast, prev_last);
      end
      if (tvalid) check("tstrb", tstrb, {(DW/8){1'b1}});
      if (tvalid && tready) rx_q.push_back({tlast, tdata});
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wren  = 1'b0;
    last  = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic write(input logic [DW-1:0] d, input logic l);
    wren = 1'b1;
    din  = d;
    last = l;
    wr_q.push_back({l, d});
    tick();
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (rx_q.size() < n) check("rx_timeout", rx_q.size(), n);
  endtask

  // Reference packetiser: TLAST on the stored last bit or on every PKT-th beat.
  task automatic check_stream(input string tag);
    int cnt = 0;
    logic exp_last;
    check({tag, "_count"}, rx_q.size(), wr_q.size());
    for (int i = 0; i < wr_q.size() && i < rx_q.size(); i++) begin
      exp_last = wr_q[i][DW] || (cnt == PKT - 1);
      cnt      = exp_last ? 0 : cnt + 1;
      check($sformatf("%s_data[%0d]", tag, i), rx_q[i][DW-1:0], wr_q[i][DW-1:0]);
      check($sformatf("%s_last[%0d]", tag, i), rx_q[i][DW], exp_last);
    end
  endtask

  initial begin
    int sent, cyc;
    logic [DW-1:0] d;
    logic l;

    do_reset();
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_tlast", tlast, 0);
    check("rst_full", full, 0);
    check("rst_ovf", ovf, 0);

    // Three-word packet with TREADY held high.
    tready = 1'b1;
    rx_q.delete();
    wr_q.delete();
    write(32'h11, 1'b0);
    check("t1_lat_e1_tvalid", tvalid, 0);
    write(32'h22, 1'b0);
    check("t1_e2_tvalid", tvalid, 1);
    check("t1_e2_tdata", tdata, 32'h11);
    check("t1_e2_tlast", tlast, 0);
    write(32'h33, 1'b1);
    wren = 1'b0;
    check("t1_e3_tdata", tdata, 32'h22);
    check("t1_e3_tlast", tlast, 0);
    tick();
    check("t1_e4_tvalid", tvalid, 1);
    check("t1_e4_tdata", tdata, 32'h33);
    check("t1_e4_tlast", tlast, 1);
    tick();
    check("t1_e5_tvalid", tvalid, 0);
    check_stream("t1");

    // Fill with TREADY low: 16 in the FIFO plus the staged beat, then a dropped write.
    tready = 1'b0;
    rx_q.delete();
    wr_q.delete();
    for (int i = 1; i <= 17; i++) begin
      write(32'hA00 + i, 1'b0);
      if (i == 16) check("t2_full_after16", full, 0);
    end
    check("t2_full_after17", full, 1);
    wren = 1'b1;
    din  = 32'hEE;
    last = 1'b1;
    tick();
    wren = 1'b0;
    last = 1'b0;
    check("t2_ovf_set", ovf, OVF_EXP);
    check("t2_full_hold", full, 1);
    repeat (3) tick();
    check("t2_ovf_held", ovf, OVF_EXP);
    check("t2_stall_tdata", tdata, 32'hA01);
    tready = 1'b1;
    wait_rx(17, 100);
    repeat (3) tick();
    check("t2_full_drained", full, 0);
    check("t2_ovf_after_drain", ovf, OVF_EXP);
    check_stream("t2");

    do_reset();
    check("rst2_ovf", ovf, 0);
    check("rst2_full", full, 0);
    check("rst2_tvalid", tvalid, 0);

    // Packet boundaries: last bits on beats 2 and 6 (6 also hits the length limit).
    tready = 1'b1;
    rx_q.delete();
    wr_q.delete();
    for (int i = 1; i <= 12; i++) write(32'hB00 + i, (i == 2) || (i == 6));
    wren = 1'b0;
    wait_rx(12, 50);
    check_stream("t3");

    // Random back-pressure and write gaps over 1000 words.
    do_reset();
    rx_q.delete();
    wr_q.delete();
    sent = 0;
    cyc  = 0;
    while ((sent < 1000 || rx_q.size() < 1000) && cyc < 20000) begin
      tready = 1'($urandom_range(0, 1));
      if (sent < 1000 && !full && $urandom_range(0, 3) != 0) begin
        d = $urandom;
        l = ($urandom_range(0, 7) == 0);
        wren = 1'b1;
        din  = d;
        last = l;
        wr_q.push_back({l, d});
        sent++;
      end else begin
        wren = 1'b0;
      end
      tick();
      cyc++;
    end
    wren   = 1'b0;
    tready = 1'b1;
    repeat (3) tick();
    check_stream("t4");

    // Reset mid-packet with a stalled beat on the bus.
    do_reset();
    tready = 1'b1;
    write(32'h501, 1'b0);
    write(32'h502, 1'b0);
    write(32'h503, 1'b0);
    wren   = 1'b0;
    tready = 1'b0;
    tick();
    check("t5_pre_tvalid", tvalid, 1);
    check("t5_pre_tdata", tdata, 32'h502);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_tvalid", tvalid, 0);
    check("t5_async_tdata", tdata, 0);
    tick();
    rst_n = 1'b1;
    rx_q.delete();
    wr_q.delete();
    repeat (3) tick();
    check("t5_post_tvalid", tvalid, 0);
    check("t5_post_full", full, 0);
    tready = 1'b1;
    for (int i = 1; i <= 4; i++) write(32'hC00 + i, 1'b0);
    wren = 1'b0;
    wait_rx(4, 50);
    check_stream("t5");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
